// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: FSM encodings, master ids,
// bus widths. Line width follows `CLP when the build provides it.
`ifndef CLP
`define CLP 128
`endif

package mem_port_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int CLSIZE = `CLP;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_I  = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  localparam logic ARB_MST_I = 1'b0;
  localparam logic ARB_MST_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-controller sides of the arbiter.
// slave: arbiter view. master: the caches/memory environment view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              I_strobe_i;
  logic [XLEN-1:0]   I_addr_i;
  logic              I_done_o;
  logic [CLSIZE-1:0] I_data_o;

  logic              D_strobe_i;
  logic [XLEN-1:0]   D_addr_i;
  logic              D_rw_i;
  logic [CLSIZE-1:0] D_data_i;
  logic              D_done_o;
  logic [CLSIZE-1:0] D_data_o;

  logic              M_strobe_o;
  logic [XLEN-1:0]   M_addr_o;
  logic              M_rw_o;
  logic [CLSIZE-1:0] M_data_o;
  logic              M_done_i;
  logic [CLSIZE-1:0] M_data_i;

  modport slave (
    input  I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
           M_done_i, M_data_i,
    output I_done_o, I_data_o, D_done_o, D_data_o,
           M_strobe_o, M_addr_o, M_rw_o, M_data_o
  );

  modport master (
    output I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
           M_done_i, M_data_i,
    input  I_done_o, I_data_o, D_done_o, D_data_o,
           M_strobe_o, M_addr_o, M_rw_o, M_data_o
  );

endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Two-way grant selector (bit 0 = I-cache, bit 1 = D-cache).
// MEM_ARB_ROUND_ROBIN_EN: ties go to the master not served last.
// Otherwise: fixed priority, D-cache wins ties, no pointer state.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,     // a grant was taken this cycle
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  assign gnt_vld_o = |req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // tie goes to whoever was not served last; single request wins outright
  always_comb begin
    gnt_id_o = req_i[1];
    if (&req_i) gnt_id_o = ~last_q;
  end

  // last-served pointer; reset to D so the first tie favours the I-cache
  always_ff @(posedge clk_i) begin
    if (rst_i)      last_q <= ARB_MST_D;
    else if (upd_i) last_q <= gnt_id_o;
  end
`else
  // D-cache request always wins (data stalls dominate)
  assign gnt_id_o = req_i[1];

  wire unused_ok = &{1'b0, clk_i, rst_i, upd_i};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory port between I-cache and D-cache.
// IDLE -> BUSY_I|BUSY_D -> RELEASE -> IDLE. The RELEASE dead cycle lets the
// served master drop its strobe so a stale strobe is never re-granted.
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (see arb_pick2).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  arb_state_e state, state_nxt;
  logic       gnt_vld, gnt_id;
  logic       load, fin_i, fin_d;

  arb_pick2 u_pick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({bus.D_strobe_i, bus.I_strobe_i}),
    .upd_i     (load),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // next state: arbitrate only in IDLE, leave BUSY on memory completion
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:               if (gnt_vld) state_nxt = gnt_id ? ARB_BUSY_D : ARB_BUSY_I;
      ARB_BUSY_I, ARB_BUSY_D: if (bus.M_done_i) state_nxt = ARB_RELEASE;
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  // control decode; M_done_i outside BUSY never reaches fin_*
  always_comb begin
    load           = (state == ARB_IDLE) && gnt_vld;
    fin_i          = (state == ARB_BUSY_I) && bus.M_done_i;
    fin_d          = (state == ARB_BUSY_D) && bus.M_done_i;
    bus.M_strobe_o = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
  end

  // request capture at grant; held stable for the whole transfer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.M_addr_o <= '0;
      bus.M_rw_o   <= 1'b0;
      bus.M_data_o <= '0;
    end else if (load) begin
      bus.M_addr_o <= gnt_id ? bus.D_addr_i : bus.I_addr_i;
      bus.M_rw_o   <= gnt_id ? bus.D_rw_i   : 1'b0;
      bus.M_data_o <= gnt_id ? bus.D_data_i : '0;
    end
  end

  // response demux: only the granted master sees done/data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.I_done_o <= 1'b0;
      bus.D_done_o <= 1'b0;
      bus.I_data_o <= '0;
      bus.D_data_o <= '0;
    end else begin
      bus.I_done_o <= fin_i;
      bus.D_done_o <= fin_d;
      if (fin_i) bus.I_data_o <= bus.M_data_i;
      if (fin_d) bus.D_data_o <= bus.M_data_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0]   addr;
    logic              rw;
    logic [CLSIZE-1:0] data;
  } req_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, cyc = 0;

  // master models
  req_t q0[$], q1[$];
  req_t cur[2];
  bit   act[2], drop[2];
  int   gap[2];
  bit   rand_on = 0, rst_req = 1, spur = 0;

  // memory model
  int mem_due = -1, mem_delay = 0;
  bit mem_prev = 0;

  // reference model: owner of the port, earliest arbitration cycle, last served
  int owner = -1, last = 1, free_cyc = 0;
  bit chk_en = 0, e_stb = 0, e_zero = 0, e_di = 0, e_dd = 0, e_rw = 0;
  logic [XLEN-1:0]   e_addr = '0;
  logic [CLSIZE-1:0] e_md = '0, e_id = '0, e_ddat = '0;

  task automatic chk(string tag, logic [CLSIZE-1:0] got, logic [CLSIZE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [CLSIZE-1:0] rnd_line();
    logic [CLSIZE-1:0] v = '0;
    for (int i = 0; i < CLSIZE; i += 32) v = (v << 32) | CLSIZE'($urandom);
    return v;
  endfunction

  task automatic master_tick(int m);
    if (rst_req) begin
      act[m] = 0; drop[m] = 0; gap[m] = 0;
    end else if (act[m]) begin
      if (drop[m]) begin
        act[m] = 0; drop[m] = 0;
        gap[m] = rand_on ? int'($urandom_range(0, 3)) : 0;
      end
    end else if (gap[m] > 0) begin
      gap[m]--;
    end else if (m == 0 && q0.size() > 0) begin
      cur[0] = q0.pop_front(); act[0] = 1;
    end else if (m == 1 && q1.size() > 0) begin
      cur[1] = q1.pop_front(); act[1] = 1;
    end else if (rand_on && $urandom_range(0, 2) == 0) begin
      cur[m].addr = $urandom & 32'hFFFF_FFC0;
      cur[m].rw   = (m == 1) ? 1'($urandom) : 1'b0;
      cur[m].data = rnd_line();
      act[m] = 1;
    end
  endtask

  task automatic drive();
    bit md;
    rst_i = rst_req;
    master_tick(0);
    master_tick(1);
    bus.I_strobe_i = act[0];
    bus.I_addr_i   = act[0] ? cur[0].addr : $urandom;
    bus.D_strobe_i = act[1];
    bus.D_addr_i   = act[1] ? cur[1].addr : $urandom;
    bus.D_rw_i     = act[1] ? cur[1].rw   : 1'($urandom);
    bus.D_data_i   = act[1] ? cur[1].data : rnd_line();
    md = 0;
    if (bus.M_strobe_o && !mem_prev)
      mem_due = cyc + ((mem_delay > 0) ? mem_delay : int'($urandom_range(1, 6)));
    mem_prev = bus.M_strobe_o;
    if (cyc == mem_due) begin
      md = 1; mem_due = -1;
    end else if (spur || (rand_on && !bus.M_strobe_o && $urandom_range(0, 15) == 0)) begin
      md = 1;
    end
    bus.M_done_i = md;
    bus.M_data_i = rnd_line();
  endtask

  task automatic check_and_update();
    int w;
    if (chk_en) begin
      chk("m_strobe", CLSIZE'(bus.M_strobe_o), CLSIZE'(e_stb));
      if (e_stb || e_zero) begin
        chk("m_addr", CLSIZE'(bus.M_addr_o), CLSIZE'(e_addr));
        chk("m_rw",   CLSIZE'(bus.M_rw_o),   CLSIZE'(e_rw));
        if (e_rw || e_zero) chk("m_wdata", bus.M_data_o, e_md);
      end
      chk("i_done", CLSIZE'(bus.I_done_o), CLSIZE'(e_di));
      chk("d_done", CLSIZE'(bus.D_done_o), CLSIZE'(e_dd));
      chk("i_data", bus.I_data_o, e_id);
      chk("d_data", bus.D_data_o, e_ddat);
    end
    // a master drops its strobe after seeing its done pulse
    if (act[0] && bus.I_done_o) drop[0] = 1;
    if (act[1] && bus.D_done_o) drop[1] = 1;
    // predict next cycle
    e_di = 0; e_dd = 0;
    if (rst_i) begin
      owner = -1; last = 1; free_cyc = cyc + 1;
      e_stb = 0; e_zero = 1; e_addr = '0; e_rw = 0; e_md = '0; e_id = '0; e_ddat = '0;
      chk_en = 1;
    end else if (owner >= 0) begin
      if (bus.M_done_i) begin
        if (owner == 0) begin e_di = 1; e_id = bus.M_data_i; end
        else            begin e_dd = 1; e_ddat = bus.M_data_i; end
        owner = -1; e_stb = 0; free_cyc = cyc + 2;
      end
    end else if (cyc >= free_cyc && (bus.I_strobe_i || bus.D_strobe_i)) begin
      if (bus.I_strobe_i && bus.D_strobe_i) w = RR ? 1 - last : 1;
      else                                  w = bus.D_strobe_i ? 1 : 0;
      owner = w; last = w; e_stb = 1; e_zero = 0;
      e_addr = w ? bus.D_addr_i : bus.I_addr_i;
      e_rw   = w ? bus.D_rw_i   : 1'b0;
      e_md   = bus.D_data_i;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    #1;
    drive();
    @(negedge clk_i);
    check_and_update();
  endtask

  initial begin
    bus.I_strobe_i = 0; bus.I_addr_i = '0;
    bus.D_strobe_i = 0; bus.D_addr_i = '0; bus.D_rw_i = 0; bus.D_data_i = '0;
    bus.M_done_i = 0;   bus.M_data_i = '0;
    act = '{0, 0}; drop = '{0, 0}; gap = '{0, 0};

    // reset
    repeat (3) step();
    rst_req = 0;

    // I-cache refill, memory answers 5 cycles after strobe
    mem_delay = 5;
    q0.push_back('{32'h8000_0040, 1'b0, '0});
    repeat (14) step();

    // D-cache write-back
    q1.push_back('{32'h8000_1000, 1'b1, {(CLSIZE/8){8'hA5}}});
    repeat (14) step();

    // ties: three back-to-back rounds per master
    mem_delay = 2;
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{32'h0000_1000 + 32'(i) * 32'h40, 1'b0, '0});
      q1.push_back('{32'h0000_2000 + 32'(i) * 32'h40, 1'b0, '0});
    end
    step();
    step();
    chk("tie_gnt", CLSIZE'(bus.M_addr_o), CLSIZE'(RR ? 32'h0000_1000 : 32'h0000_2000));
    repeat (40) step();

    // reset in the middle of a D refill; the late M_done_i must be ignored
    mem_delay = 10;
    q1.push_back('{32'h8000_3000, 1'b0, '0});
    repeat (4) step();
    rst_req = 1;
    step();
    rst_req = 0;
    repeat (14) step();

    // spurious completion while idle
    spur = 1;
    step();
    spur = 0;
    repeat (4) step();

    // random traffic
    mem_delay = 0;
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
